hamming_stream_encoder: RTL
===========================

# hamming_stream_encoder

Parametrised, back-pressurable Hamming encoder for the SSD RAID write path. It accepts a data word and its address on a valid/ready stream and encodes the data into a single-error-correcting Hamming codeword. An optional overall parity bit extends the code to SECDED. Results are buffered in a 2-entry output queue, so the encoder sits between the host write port and the RAID stripe writer without dropping words when the writer stalls.

## Interface
Parameters:
- DATA_W, 8: data bits per word, 4..64.
- ADDR_W, 8: address bits carried alongside the data.
- CNT_W, 16: width of the encoded-word counter.

Derived constants:
- R: the smallest R with 2^R >= DATA_W+R+1.
- CODE_W: DATA_W+R, plus 1 when HAMMING_SECDED_EN is defined.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: the input word is presented.
- in_ready, output, 1: the block can accept a word this cycle.
- data_in, input, DATA_W: data to encode.
- address_in, input, ADDR_W: address tag for the word.
- out_valid, output, 1: the head codeword is presented.
- out_ready, input, 1: the downstream block takes the head codeword.
- enc_data, output, CODE_W: codeword.
- address_out, output, ADDR_W: address belonging to enc_data.
- word_cnt, output, CNT_W: number of codewords delivered, wrapping.

## Operation
- **Accept** occurs when in_valid && in_ready. **Deliver** occurs when out_valid && out_ready.
- **Codeword layout:** code position p = bit index + 1.
  - Parity bit Pk (k = 0..R-1) sits at position 2^k.
  - Data bits fill the remaining positions in ascending order, with data_in[0] at the lowest free position.
  - Pk is the XOR of all data bits whose position has bit k set.
  - With DATA_W=8, enc_data = {d7,d6,d5,d4,P3,d3,d2,d1,P2,d0,P1,P0}.
- **HAMMING_SECDED_EN:** enc_data[CODE_W-1] is the XOR of enc_data[CODE_W-2:0], giving even overall parity.
- **Queue:**
  - Encoding is combinational on data_in. The codeword and address are written into a 2-entry FIFO on accept.
  - The FIFO uses a 2-bit occupancy count and a 1-bit read pointer.
  - The head entry drives enc_data and address_out.
- **Flow control:**
  - in_ready = (count != 2) and is driven from registered state only.
  - out_valid = (count != 0).
  - Occupancy update per cycle:
    - accept only: count+1
    - deliver only: count-1
    - accept and deliver together (possible at count 1; at count 0 only accept counts, because out_valid is low): count unchanged, entry order preserved.
- **Back-pressure:** while count = 2, in_ready = 0 and any in_valid is ignored. Data on data_in is not consumed.
- **Output stability:** while out_valid=1 and out_ready=0, enc_data and address_out hold stable.
- **word_cnt:** increments by 1 on every deliver and wraps from 2^CNT_W-1 to 0.
- **Illegal input:** in_valid X/Z is treated as an error in simulation only, via an assertion. No RTL handling.

## Timing
- **Reset values:** in_ready=1, out_valid=0, enc_data=0, address_out=0, word_cnt=0, FIFO count=0, pointers=0.
- **Reset mid-operation:** buffered words are discarded immediately and asynchronously. word_cnt clears.
- **Latency:** a word accepted at edge N is on enc_data with out_valid=1 after edge N.
- **Throughput:** 1 word/cycle while out_ready stays high.
- **Stall and release:** with out_ready low, 2 words are accepted and in_ready falls after the second accept. in_ready rises the cycle after the first deliver.
- **Paths:** there is no combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Configuration
- **HAMMING_SECDED_EN defined:**
  - The overall parity bit is appended as the MSB.
  - CODE_W = DATA_W+R+1; for DATA_W=8, CODE_W=13.
- **HAMMING_SECDED_EN undefined:**
  - Plain SEC Hamming code, CODE_W = DATA_W+R; for DATA_W=8, CODE_W=12.
  - Bit-compatible with the existing 8-bit encoder format.

## Structure
- **Package hamming_pkg** holds:
  - the function calc_r(data_w), returning R;
  - the function code_w(data_w), which honours HAMMING_SECDED_EN;
  - the function is_pow2(pos), for parity placement.
  The downstream decoder imports the same package.
- **Sub-module hamming_enc_core:**
  - Purely combinational; parameter DATA_W; data in, codeword out.
  - Built from generate loops over positions.
- **Top level:** instantiates hamming_enc_core once and contains the FIFO, handshakes and counter.

## Test plan
- **Basic codewords:** DATA_W=8, SEC, out_ready=1. Send 0x00, 0x01, 0xFF.
  - enc_data = 0x000, 0x007, 0xF77, each one cycle after accept.
  - word_cnt = 3 afterwards.
- **SECDED codewords:** same stimulus with HAMMING_SECDED_EN.
  - enc_data = 0x0000, 0x1007, 0x0F77.
- **Back-pressure:** out_ready=0; drive 3 consecutive words (addresses 0x10, 0x11, 0x12).
  - in_ready drops after the 2nd accept.
  - Raise out_ready: outputs appear in order 0x10, 0x11, then 0x12 is accepted and delivered. No loss or duplication.
- **Simultaneous accept and deliver:** count=1, in_valid=1, out_ready=1 for 20 cycles.
  - count stays 1, 1 word/cycle, addresses in order.
- **Reset mid-operation:** assert reset_n=0 with 2 words buffered.
  - out_valid=0 and in_ready=1 immediately; word_cnt=0; after release no stale word is delivered.
- **Random and wrap:**
  - Random data, DATA_W = 4, 11, 26, 57; check each codeword against a reference model; single-bit flips give distinct non-zero syndromes.
  - CNT_W=4: the 16th deliver wraps word_cnt to 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming code geometry helpers shared by encoder and decoder; honours HAMMING_SECDED_EN
package hamming_pkg;

  // Smallest R with 2^R >= data_w + R + 1
  function automatic int calc_r(input int data_w);
    int r;
    r = 0;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  // Codeword width, including the overall parity bit when SECDED is built in
  function automatic int code_w(input int data_w);
`ifdef HAMMING_SECDED_EN
    return data_w + calc_r(data_w) + 1;
`else
    return data_w + calc_r(data_w);
`endif
  endfunction

  // Parity bits live at power-of-two code positions
  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bit index held at a non-power-of-two position: skip the parity slots at or below it
  function automatic int data_idx(input int pos);
    return pos - $clog2(pos + 1) - 1;
  endfunction

endpackage

// File: rtl/hamming_stream_encoder_if.sv
// rtl/hamming_stream_encoder_if.sv - Write-path stream bundle for the Hamming encoder
interface hamming_stream_encoder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  import hamming_pkg::*;

  localparam int CODE_W = code_w(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] address_in;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] enc_data;
  logic [ADDR_W-1:0] address_out;
  logic [CNT_W-1:0]  word_cnt;

  modport master (
    output in_valid, data_in, address_in, out_ready,
    input  in_ready, out_valid, enc_data, address_out, word_cnt
  );

  modport slave (
    input  in_valid, data_in, address_in, out_ready,
    output in_ready, out_valid, enc_data, address_out, word_cnt
  );

endinterface

// File: rtl/hamming_enc_core.sv
// rtl/hamming_enc_core.sv - Combinational Hamming SEC encoder, overall parity MSB under HAMMING_SECDED_EN
module hamming_enc_core
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]         data,
  output logic [code_w(DATA_W)-1:0] code
);
  localparam int R     = calc_r(DATA_W);
  localparam int SEC_W = DATA_W + R;

  logic [SEC_W-1:0] spread;
  logic [SEC_W-1:0] sec;

  // Data bits scattered into their code positions, parity slots left at zero
  for (genvar p = 1; p <= SEC_W; p++) begin : g_spread
    if (is_pow2(p)) begin : g_slot
      assign spread[p-1] = 1'b0;
    end else begin : g_bit
      assign spread[p-1] = data[data_idx(p)];
    end
  end

  // Parity at position 2^k covers every position whose index has bit k set
  for (genvar p = 1; p <= SEC_W; p++) begin : g_code
    if (is_pow2(p)) begin : g_par
      logic [SEC_W-1:0] cov_bits;
      for (genvar q = 1; q <= SEC_W; q++) begin : g_cov
        assign cov_bits[q-1] = ((q / p) % 2 == 1) ? spread[q-1] : 1'b0;
      end
      assign sec[p-1] = ^cov_bits;
    end else begin : g_dat
      assign sec[p-1] = spread[p-1];
    end
  end

`ifdef HAMMING_SECDED_EN
  assign code = {^sec, sec};
`else
  assign code = sec;
`endif

endmodule

// File: rtl/hamming_stream_encoder.sv
// rtl/hamming_stream_encoder.sv - Stream Hamming encoder with 2-entry output queue; HAMMING_SECDED_EN adds overall parity
module hamming_stream_encoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  hamming_stream_encoder_if.slave bus
);
  localparam int CODE_W = code_w(DATA_W);

  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] q_code [2];
  logic [ADDR_W-1:0] q_addr [2];
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic              accept;
  logic              deliver;
  logic [CNT_W-1:0]  cnt;

  hamming_enc_core #(.DATA_W(DATA_W)) u_core (
    .data (bus.data_in),
    .code (code)
  );

  // Handshakes come from registered occupancy only, so out_ready never reaches in_ready
  assign bus.in_ready    = (count != 2'd2);
  assign bus.out_valid   = (count != 2'd0);
  assign bus.enc_data    = q_code[rd_ptr];
  assign bus.address_out = q_addr[rd_ptr];
  assign bus.word_cnt    = cnt;

  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = bus.out_valid && bus.out_ready;
  // Tail slot: same as head when empty, the other slot when one entry is held
  assign wr_ptr  = rd_ptr ^ count[0];

  // Queue storage: the fresh codeword lands in the tail slot on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        q_code[i] <= '0;
        q_addr[i] <= '0;
      end
    end else if (accept) begin
      q_code[wr_ptr] <= code;
      q_addr[wr_ptr] <= bus.address_in;
    end
  end

  // Occupancy count and head pointer; simultaneous accept and deliver leaves count alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
    end else begin
      case ({accept, deliver})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (deliver) rd_ptr <= ~rd_ptr;
    end
  end

  // Wrapping count of delivered codewords
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (deliver) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // An unknown in_valid out of reset is a caller bug
  assert property (@(posedge clk) disable iff (!reset_n) !$isunknown(bus.in_valid));

endmodule
